// File: rtl/fifo_rd_stream.sv
// Read-side consumer of an async FIFO: credit-based popping into a circular skid
// buffer drained over valid/ready. Optional word-sequence monitor: FIFO_RD_SEQ_CHECK_EN.
module fifo_rd_stream #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic                     rempty,
  input  logic [DATA_W-1:0]        rdata,
  input  logic                     rvalid,
  output logic                     rinc,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     seq_err,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic              en_q, en_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [LVL_W:0]    occ;
  logic              xfer, full, cap_req, drop, wr_en;

  // A pop still in flight holds a slot, so the buffer can never be over-committed.
  assign occ     = {1'b0, level_q} + (LVL_W+1)'(inflight_q);
  assign rinc    = en_q && !rempty && (occ < (LVL_W+1)'(DEPTH));
  assign m_valid = (level_q != '0);
  assign m_data  = mem_q[rd_ptr_q];
  assign xfer    = m_valid && m_ready;
  assign full    = (level_q == LVL_W'(DEPTH));
  assign cap_req = rvalid && en_q;
  assign drop    = cap_req && full && !xfer;
  assign wr_en   = cap_req && !drop;
  assign level   = level_q;
  assign ovf     = ovf_q;

  always_comb begin
    en_d       = 1'b1;
    inflight_d = rinc;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q || drop;
    mem_d      = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = rdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (xfer) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, xfer})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      en_q       <= 1'b0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      en_q       <= en_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
    end
  end

`ifdef FIFO_RD_SEQ_CHECK_EN
  logic              seen_q, seen_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              seq_err_q, seq_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Expected value always re-bases on the received word, so one glitch counts once.
  always_comb begin
    seen_d    = seen_q;
    exp_d     = exp_q;
    seq_err_d = seq_err_q;
    err_cnt_d = err_cnt_q;
    if (wr_en) begin
      seen_d = 1'b1;
      exp_d  = rdata + DATA_W'(1);
      if (seen_q && (rdata != exp_q)) begin
        seq_err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      seen_q    <= 1'b0;
      exp_q     <= '0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      seen_q    <= seen_d;
      exp_q     <= exp_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign seq_err = seq_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign seq_err = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed vector table, hand sequences for overflow and
// mid-operation reset, and randomized traffic against a queue-based reference model.
module tb_fifo_rd_stream;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rinc;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [2:0]    level;
  logic          ovf;
  logic          seq_err;
  logic [CW-1:0] err_cnt;

  fifo_rd_stream #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rvalid(rvalid),
    .rinc(rinc), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .ovf(ovf), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: buffer contents as a queue, one credit bit, enable, sticky overflow.
  logic [DW-1:0] m_buf[$];
  int            m_inf;
  bit            m_en;
  bit            m_ovf;
  // FIFO source model
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_out[$];
  bit            pend_vld;
  logic [DW-1:0] pend_data;

  task automatic do_reset();
    rrst_n = 1'b0; rempty = 1'b1; rvalid = 1'b0; rdata = '0; m_ready = 1'b0;
    m_buf.delete(); m_inf = 0; m_en = 0; m_ovf = 0; pend_vld = 0;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic run(input int nwords, input int gap_pct, input int stall_pct,
                     input bit toggle, input bit want_no_gaps);
    int got = 0, cyc = 0, gaps = 0;
    bit exp_rinc, xfer, dut_rinc;
    int pre;
    while (got < nwords && cyc < 3000) begin
      rempty  = (src_q.size() == 0) || ($urandom_range(99) < gap_pct);
      m_ready = toggle ? cyc[0] : ($urandom_range(99) >= stall_pct);
      rvalid  = pend_vld;
      rdata   = pend_vld ? pend_data : DW'($urandom);
      #1;
      exp_rinc = m_en && !rempty && (m_buf.size() + m_inf < DEPTH);
      xfer     = (m_buf.size() != 0) && m_ready;
      chk("rinc", 32'(rinc), 32'(exp_rinc));
      chk("m_valid", 32'(m_valid), 32'(m_buf.size() != 0));
      chk("level", 32'(level), 32'(m_buf.size()));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (xfer) begin
        chk("stream_data", 32'(m_data), 32'(exp_out[got]));
        got++;
      end else if (got > 0 && got < nwords) gaps++;
      dut_rinc = rinc;
      @(posedge rclk);
      pre = m_buf.size();
      if (xfer) void'(m_buf.pop_front());
      if (m_en && rvalid) begin
        if (pre == DEPTH && !xfer) m_ovf = 1;
        else m_buf.push_back(rdata);
      end
      m_inf = exp_rinc;
      m_en  = 1;
      if (dut_rinc && !rempty && src_q.size() != 0) begin
        pend_data = src_q.pop_front();
        pend_vld  = 1;
      end else pend_vld = 0;
      @(negedge rclk);
      cyc++;
    end
    chk("delivered_count", 32'(got), 32'(nwords));
    if (want_no_gaps) chk("throughput_gaps", 32'(gaps), 32'd0);
  endtask

  task automatic load_seq(input int base, input int n);
    src_q.delete(); exp_out.delete();
    for (int i = 0; i < n; i++) begin
      src_q.push_back(DW'(base + i));
      exp_out.push_back(DW'(base + i));
    end
  endtask

  typedef struct {
    logic          rempty, m_ready, rvalid;
    logic [DW-1:0] rdata;
    logic          e_rinc, e_mvalid;
    logic [2:0]    e_level;
    logic [DW-1:0] e_mdata;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0,0,0,16'h0,    0,0,3'd0,16'h0};
    tbl[1]  = '{0,0,0,16'h0,    1,0,3'd0,16'h0};
    tbl[2]  = '{0,0,1,16'hA000, 1,0,3'd0,16'h0};
    tbl[3]  = '{0,0,1,16'hA001, 1,1,3'd1,16'hA000};
    tbl[4]  = '{0,0,1,16'hA002, 1,1,3'd2,16'hA000};
    tbl[5]  = '{0,0,1,16'hA003, 0,1,3'd3,16'hA000};
    tbl[6]  = '{0,0,0,16'h0,    0,1,3'd4,16'hA000};
    tbl[7]  = '{0,1,0,16'h0,    0,1,3'd4,16'hA000};
    tbl[8]  = '{0,1,0,16'h0,    1,1,3'd3,16'hA001};
    tbl[9]  = '{0,1,1,16'hA004, 1,1,3'd2,16'hA002};
    tbl[10] = '{0,0,1,16'hA005, 1,1,3'd2,16'hA003};
    tbl[11] = '{0,0,1,16'hA006, 0,1,3'd3,16'hA003};

    rrst_n = 1'b0; rempty = 1'b1; rvalid = 1'b0; rdata = '0; m_ready = 1'b0;
    #2;
    chk("rst_rinc", 32'(rinc), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_seq_err", 32'(seq_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);

    // idle after release with an empty FIFO
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rempty = 1'b1; m_ready = 1'b1;
      #1;
      chk("idle_rinc", 32'(rinc), 0);
      chk("idle_m_valid", 32'(m_valid), 0);
      chk("idle_level", 32'(level), 0);
      @(negedge rclk);
    end

    // fill with m_ready low, drain, resume
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rempty = tbl[i].rempty; m_ready = tbl[i].m_ready;
      rvalid = tbl[i].rvalid; rdata = tbl[i].rdata;
      #1;
      chk($sformatf("tbl%0d_rinc", i), 32'(rinc), 32'(tbl[i].e_rinc));
      chk($sformatf("tbl%0d_mvalid", i), 32'(m_valid), 32'(tbl[i].e_mvalid));
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].e_level));
      if (tbl[i].e_mvalid) chk($sformatf("tbl%0d_mdata", i), 32'(m_data), 32'(tbl[i].e_mdata));
      @(negedge rclk);
    end

    // protocol violation: word arrives while full and stalled
    rempty = 1'b1; m_ready = 1'b0; rvalid = 1'b1; rdata = 16'hDEAD;
    #1;
    chk("pre_ovf", 32'(ovf), 0);
    @(negedge rclk);
    rvalid = 1'b0;
    #1;
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_level", 32'(level), 4);
    chk("ovf_hold_data", 32'(m_data), 32'h0000A003);
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      m_ready = 1'b1;
      #1;
      chk("ovf_drain_valid", 32'(m_valid), 1);
      chk("ovf_drain_data", 32'(m_data), 32'(16'hA003 + i));
    end
    @(negedge rclk);
    #1;
    chk("ovf_drain_level", 32'(level), 0);
    chk("ovf_sticky", 32'(ovf), 1);

    // reset while holding three words
    do_reset();
    begin
      bit prev_rinc = 0;
      for (int i = 0; i < 5; i++) begin
        rempty = 1'b0; m_ready = 1'b0; rvalid = prev_rinc; rdata = DW'(16'hB000 + i);
        #1;
        prev_rinc = rinc;
        @(negedge rclk);
      end
    end
    rvalid = 1'b0;
    #1;
    chk("midrst_pre_level", 32'(level), 3);
    rrst_n = 1'b0;
    #1;
    chk("midrst_rinc", 32'(rinc), 0);
    chk("midrst_m_valid", 32'(m_valid), 0);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    chk("midrst_m_data", 32'(m_data), 0);
    @(negedge rclk);
    rrst_n = 1'b1; rempty = 1'b0; rvalid = 1'b1; rdata = 16'h1234;
    #1;
    chk("post_rst_dead_rinc", 32'(rinc), 0);
    @(negedge rclk);
    rvalid = 1'b0;
    #1;
    chk("post_rst_stray_ignored", 32'(level), 0);
    chk("post_rst_first_rinc", 32'(rinc), 1);

    // sequence monitor: 0,1,2,5,6 gives exactly one error
    do_reset();
    src_q = '{16'd0, 16'd1, 16'd2, 16'd5, 16'd6};
    exp_out = src_q;
    run(5, 0, 0, 0, 0);
`ifdef FIFO_RD_SEQ_CHECK_EN
    chk("seq_err_inject", 32'(seq_err), 1);
    chk("err_cnt_inject", 32'(err_cnt), 1);
`else
    chk("seq_err_tied", 32'(seq_err), 0);
    chk("err_cnt_tied", 32'(err_cnt), 0);
`endif

    // full-rate streaming 0..31
    do_reset();
    load_seq(0, 32);
    run(32, 0, 0, 0, 1);
    chk("stream_seq_err", 32'(seq_err), 0);

    // ready toggling every cycle
    do_reset();
    load_seq(16'h0100, 40);
    run(40, 0, 0, 1, 0);

    // random gaps and stalls
    for (int r = 0; r < 3; r++) begin
      do_reset();
      load_seq(16'hFFF0 + r, 60);
      run(60, 10 + 15 * r, 20 + 15 * r, 0, 0);
      chk("rand_seq_err", 32'(seq_err), 0);
      chk("rand_ovf", 32'(ovf), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-domain consumer of async_fifo_top. Runs entirely on rclk.
- Pops the FIFO (rinc) whenever it is non-empty and local space is guaranteed.
- Captures rdata on rvalid into a small circular skid buffer.
- Presents buffered words to downstream logic on a valid/ready stream.

Parameters:
- DATA_W, 16, width of FIFO read data and stream data.
- DEPTH, 4, skid buffer entries; power of 2, minimum 2.
- CNT_W, 8, width of the error counter (optional feature only).

Ports:
- rclk  input  1  read-domain clock.
- rrst_n  input  1  asynchronous active-low reset.
- rempty  input  1  FIFO empty flag, rclk domain.
- rdata  input  DATA_W  FIFO read data; valid only when rvalid=1.
- rvalid  input  1  FIFO read-data valid; asserts exactly 1 rclk after a cycle with rinc=1 and rempty=0.
- rinc  output  1  FIFO pop request.
- m_data  output  DATA_W  stream data (head of buffer).
- m_valid  output  1  stream valid.
- m_ready  input  1  downstream ready.
- level  output  $clog2(DEPTH)+1  current buffer occupancy.
- ovf  output  1  sticky overflow flag.
- seq_err  output  1  sticky sequence error (optional feature).
- err_cnt  output  CNT_W  saturating sequence-error count (optional feature).

Behaviour:
- Reset (async assert, rrst_n=0):
  - rinc=0, m_valid=0, level=0, ovf=0, seq_err=0, err_cnt=0, m_data=0.
  - Buffer pointers=0, inflight=0, en=0.
- Start-up: en is a register set to 1 on the first rclk edge after rrst_n deasserts. rinc stays 0 while en=0, giving one dead cycle after reset.
- Pop request:
  - rinc = en && !rempty && (level + inflight) < DEPTH. Combinational from registers and rempty.
  - inflight <= (rinc && !rempty) each cycle. This is the 1-bit credit for a pop whose data has not yet arrived.
- Capture: when rvalid=1, write rdata to mem[wr_ptr] and advance wr_ptr (wraps modulo DEPTH).
- Drain:
  - m_valid = (level != 0); m_data = mem[rd_ptr].
  - A transfer occurs when m_valid && m_ready; rd_ptr then advances (wraps modulo DEPTH).
  - m_data must hold stable while m_valid=1 and m_ready=0.
- Occupancy:
  - Capture and transfer in the same cycle: level unchanged, both pointers advance.
  - Capture only: level+1. Transfer only: level-1.
- Full: with level + inflight == DEPTH, rinc=0 even if rempty=0. Popping resumes in the cycle after a transfer frees space.
- Empty: with level == 0, m_valid=0 and m_ready is ignored.
- Overflow: rvalid=1 while level==DEPTH and no transfer in that cycle means the word is dropped, ovf sets and stays set until reset. Unreachable under the credit rule; exists as a protocol monitor.
- Throughput: a steady 1 word/cycle with m_ready=1 and FIFO non-empty. Latency from rinc to m_valid is 2 rclk.
- Reset mid-operation: all state clears immediately. Buffered and in-flight data are discarded; any rvalid arriving while en=0 is ignored.

Optional Feature:
- Macro: FIFO_RD_SEQ_CHECK_EN.
- With macro:
  - The first word captured after reset loads an expected-value register.
  - Each later captured word must equal previous+1 modulo 2^DATA_W.
  - On mismatch: seq_err sets (sticky) and err_cnt increments, saturating at 2^CNT_W-1.
  - The expected value always re-bases on the received word.
- Without macro: no check logic; seq_err and err_cnt are tied to 0.

Test Plan:
- Reset then release with rempty=1 for 10 cycles -> rinc=0 throughout, m_valid=0, level=0.
- FIFO feeding 0,1,2,...,31 with m_ready=1 -> m_data sequence 0..31 in order, no gaps after the first word, ovf=0, seq_err=0.
- m_ready=0 with FIFO non-empty -> rinc stops after 4 pops, level=4, m_data holds the first word. Then m_ready=1 -> drains 4 words and popping resumes.
- m_ready toggling every cycle at level=2 -> level stays bounded ≤4, all words delivered once in order, ovf=0.
- With FIFO_RD_SEQ_CHECK_EN, inject 0,1,2,5,6 -> seq_err=1 after word 5, err_cnt=1. No further increment for 6.
- Assert rrst_n=0 at level=3 -> all outputs go to reset values immediately. After release, the first rinc occurs no earlier than the 2nd rclk edge.
